// File: rtl/apb_master_arbiter_if.sv
// Bundles the two requester ports and the APB slave port of apb_master_arbiter.
// The master modport is the arbiter's view; the slave modport is the view of
// whatever drives the requests and models the APB slave.
interface apb_master_arbiter_if;
  // requester 0
  logic       req0;
  logic       wr0;
  logic [7:0] addr0;
  logic [7:0] wdata0;
  logic       done0;
  // requester 1
  logic       req1;
  logic       wr1;
  logic [7:0] addr1;
  logic [7:0] wdata1;
  logic       done1;
  // shared completion status
  logic       err;
  logic [7:0] rdata;
  // APB slave port
  logic       apb_sel;
  logic       apb_enable;
  logic       apb_w_en;
  logic [7:0] apb_add;
  logic [7:0] apb_wdata;
  logic       apb_ready;
  logic [7:0] apb_rdata;

  modport master (
    input  req0, wr0, addr0, wdata0,
    input  req1, wr1, addr1, wdata1,
    input  apb_ready, apb_rdata,
    output done0, done1, err, rdata,
    output apb_sel, apb_enable, apb_w_en, apb_add, apb_wdata
  );

  modport slave (
    output req0, wr0, addr0, wdata0,
    output req1, wr1, addr1, wdata1,
    output apb_ready, apb_rdata,
    input  done0, done1, err, rdata,
    input  apb_sel, apb_enable, apb_w_en, apb_add, apb_wdata
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration between req0/req1, the
// APB SETUP/ACCESS sequence, wait states via apb_ready and an optional
// timeout abort. Every output is a register.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  S_IDLE   | no transfer; picks an eligible requester (own done masks it)
//  S_SETUP  | apb_sel=1, apb_enable=0; exactly one cycle
//  S_ACCESS | apb_sel=1, apb_enable=1; waits for apb_ready or timeout
module apb_master_arbiter #(
  parameter int TIMEOUT = 16,  // ACCESS cycles without apb_ready before abort; 0 disables
  parameter int CNT_W   = 8    // timeout counter width; TIMEOUT < 2**CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  apb_master_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  // Counter value seen at the edge that ends the TIMEOUT-th wait cycle.
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);
  localparam bit TO_ENABLED = (TIMEOUT != 0);

  state_t           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;  // also the id of the transfer in flight
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             sel_q, sel_d;
  logic             enable_q, enable_d;
  logic             w_en_q, w_en_d;
  logic [7:0]       add_q, add_d;
  logic [7:0]       wdata_q, wdata_d;

  logic             elig0, elig1;
  logic             gnt;
  logic             finish;

  // A requester whose done is high this cycle is still holding req; skip it once.
  assign elig0 = bus.req0 & ~done0_q;
  assign elig1 = bus.req1 & ~done1_q;

  // Next-state and next-output logic; every register holds unless changed below.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    sel_d      = sel_q;
    enable_d   = enable_q;
    w_en_d     = w_en_q;
    add_d      = add_q;
    wdata_d    = wdata_q;
    gnt        = 1'b0;
    finish     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (elig0 || elig1) begin
          // On a tie the requester that did not win last time gets the bus.
          gnt        = (elig0 && elig1) ? ~last_gnt_q : elig1;
          last_gnt_d = gnt;
          w_en_d     = gnt ? bus.wr1    : bus.wr0;
          add_d      = gnt ? bus.addr1  : bus.addr0;
          wdata_d    = gnt ? bus.wdata1 : bus.wdata0;
          sel_d      = 1'b1;
          state_d    = S_SETUP;
        end
      end

      S_SETUP: begin
        enable_d = 1'b1;
        cnt_d    = {CNT_W{1'b0}};
        state_d  = S_ACCESS;
      end

      S_ACCESS: begin
        if (bus.apb_ready) begin
          // Ready wins even on the cycle the timeout would fire.
          rdata_d = w_en_q ? 8'h00 : bus.apb_rdata;
          err_d   = 1'b0;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TO_ENABLED && (cnt_q == TO_LAST)) begin
            rdata_d = 8'h00;
            err_d   = 1'b1;
            finish  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish) begin
      done0_d  = ~last_gnt_q;
      done1_d  = last_gnt_q;
      sel_d    = 1'b0;
      enable_d = 1'b0;
      state_d  = S_IDLE;
    end
  end

  // State and output registers; reset drops every output at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= {CNT_W{1'b0}};
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 8'h00;
      sel_q      <= 1'b0;
      enable_q   <= 1'b0;
      w_en_q     <= 1'b0;
      add_q      <= 8'h00;
      wdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      sel_q      <= sel_d;
      enable_q   <= enable_d;
      w_en_q     <= w_en_d;
      add_q      <= add_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.apb_sel    = sel_q;
  assign bus.apb_enable = enable_q;
  assign bus.apb_w_en   = w_en_q;
  assign bus.apb_add    = add_q;
  assign bus.apb_wdata  = wdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: one instance with TIMEOUT=16 and one
// with the timeout disabled, driven on the falling edge and sampled there too.
module tb_apb_master_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  apb_master_arbiter_if ifa ();
  apb_master_arbiter_if ifb ();

  apb_master_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  apb_master_arbiter #(.TIMEOUT(0), .CNT_W(8)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int en;
    int dn;
    int guard;
    int ndone;
    int t;
    bit overlap;
    bit sel_in_done;
    bit saw;
    int         gid  [8];
    int         gt   [8];
    logic [7:0] gadd [8];
    logic [7:0] grd  [8];

    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifa.req0 = 0; ifa.wr0 = 0; ifa.addr0 = 0; ifa.wdata0 = 0;
    ifa.req1 = 0; ifa.wr1 = 0; ifa.addr1 = 0; ifa.wdata1 = 0;
    ifa.apb_ready = 0; ifa.apb_rdata = 0;
    ifb.req0 = 0; ifb.wr0 = 0; ifb.addr0 = 0; ifb.wdata0 = 0;
    ifb.req1 = 0; ifb.wr1 = 0; ifb.addr1 = 0; ifb.wdata1 = 0;
    ifb.apb_ready = 0; ifb.apb_rdata = 0;

    // ---- reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ctl", {ifa.done0, ifa.done1, ifa.err, ifa.apb_sel, ifa.apb_enable, ifa.apb_w_en}, 0);
    check("rst_data", {ifa.apb_add, ifa.apb_wdata, ifa.rdata}, 0);
    rst = 1'b0;
    tick();

    // ---- 1: req0 write CD/EE, ready tied high
    ifa.apb_ready = 1;
    ifa.req0 = 1; ifa.wr0 = 1; ifa.addr0 = 8'hCD; ifa.wdata0 = 8'hEE;
    tick();
    check("t1_setup_sel_en", {ifa.apb_sel, ifa.apb_enable, ifa.done0}, 3'b100);
    tick();
    check("t1_access_ctl", {ifa.apb_sel, ifa.apb_enable, ifa.apb_w_en, ifa.done0}, 4'b1110);
    check("t1_access_add_wdata", {ifa.apb_add, ifa.apb_wdata}, 16'hCDEE);
    tick();
    check("t1_done", {ifa.done0, ifa.done1, ifa.err, ifa.apb_sel, ifa.apb_enable}, 5'b10000);
    check("t1_rdata", ifa.rdata, 8'h00);
    ifa.req0 = 0;
    tick();
    check("t1_done_pulse", ifa.done0, 1'b0);

    // ---- 2: req1 read 10, three wait states then 5A
    ifa.apb_ready = 0; ifa.apb_rdata = 8'h33;
    ifa.req1 = 1; ifa.wr1 = 0; ifa.addr1 = 8'h10;
    tick();
    check("t2_setup", {ifa.apb_sel, ifa.apb_enable}, 2'b10);
    tick();
    en = 0; dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (ifa.apb_enable) en++;
      if (ifa.done1) dn++;
      if (i == 3) begin
        ifa.apb_ready = 1; ifa.apb_rdata = 8'h5A;
      end
      tick();
    end
    check("t2_enable_cycles", en, 4);
    check("t2_early_done", dn, 0);
    check("t2_done", {ifa.done1, ifa.done0, ifa.err, ifa.apb_sel, ifa.apb_enable}, 5'b10000);
    check("t2_rdata", ifa.rdata, 8'h5A);
    check("t2_add_wen", {ifa.apb_add, ifa.apb_w_en}, {8'h10, 1'b0});
    ifa.req1 = 0;
    tick();
    check("t2_done_once", ifa.done1, 1'b0);
    check("t2_rdata_hold", ifa.rdata, 8'h5A);

    // ---- 3: both requesters hold req, four transfers each
    ifa.apb_ready = 1; ifa.apb_rdata = 8'h77;
    ifa.req0 = 1; ifa.wr0 = 1; ifa.addr0 = 8'h20; ifa.wdata0 = 8'hAB;
    ifa.req1 = 1; ifa.wr1 = 0; ifa.addr1 = 8'h21;
    ndone = 0; t = 0; overlap = 0; sel_in_done = 0;
    while (ndone < 8 && t < 40) begin
      tick();
      t++;
      if (ifa.done0 && ifa.done1) overlap = 1;
      if (ifa.done0 || ifa.done1) begin
        if (ifa.apb_sel) sel_in_done = 1;
        gid[ndone]  = ifa.done1 ? 1 : 0;
        gt[ndone]   = t;
        gadd[ndone] = ifa.apb_add;
        grd[ndone]  = ifa.rdata;
        ndone++;
        if (ndone == 8) begin
          ifa.req0 = 0; ifa.req1 = 0;
        end
      end
    end
    check("t3_done_count", ndone, 8);
    check("t3_no_overlap", overlap, 1'b0);
    check("t3_sel_low_in_done", sel_in_done, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_grant_%0d", k), gid[k], k % 2);
      check($sformatf("t3_time_%0d", k), gt[k], 3 * (k + 1));
      check($sformatf("t3_add_%0d", k), gadd[k], (k % 2) ? 8'h21 : 8'h20);
      check($sformatf("t3_rdata_%0d", k), grd[k], (k % 2) ? 8'h77 : 8'h00);
    end
    tick();

    // ---- 4: ready stuck low, abort after 16 ACCESS cycles
    ifa.apb_ready = 0; ifa.apb_rdata = 8'hFF;
    ifa.req0 = 1; ifa.wr0 = 1; ifa.addr0 = 8'h40; ifa.wdata0 = 8'h11;
    tick();
    en = 0; guard = 0;
    while (ifa.done0 !== 1'b1 && guard < 40) begin
      if (ifa.apb_enable) en++;
      tick();
      guard++;
    end
    check("t4_access_cycles", en, 16);
    check("t4_abort", {ifa.done0, ifa.err, ifa.apb_sel, ifa.apb_enable}, 4'b1100);
    check("t4_rdata", ifa.rdata, 8'h00);
    ifa.req0 = 0;
    tick();
    check("t4_err_hold", {ifa.done0, ifa.err}, 2'b01);
    ifa.apb_ready = 1; ifa.apb_rdata = 8'h99;
    ifa.req0 = 1; ifa.wr0 = 0; ifa.addr0 = 8'h41;
    tick(); tick(); tick();
    check("t4_next_ok", {ifa.done0, ifa.err}, 2'b10);
    check("t4_next_rdata", ifa.rdata, 8'h99);
    ifa.req0 = 0;
    tick();

    // ---- 4b: ready arrives on the would-be abort edge
    ifa.apb_ready = 0; ifa.apb_rdata = 8'hC3;
    ifa.req1 = 1; ifa.wr1 = 0; ifa.addr1 = 8'h42;
    tick();
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) ifa.apb_ready = 1;
      tick();
    end
    check("t4b_ready_wins", {ifa.done1, ifa.err}, 2'b10);
    check("t4b_rdata", ifa.rdata, 8'hC3);
    ifa.req1 = 0;
    tick();

    // ---- 5: reset during ACCESS
    ifa.apb_ready = 0; ifa.apb_rdata = 8'h00;
    ifa.req0 = 1; ifa.wr0 = 1; ifa.addr0 = 8'h50; ifa.wdata0 = 8'h5C;
    tick();
    tick();
    check("t5_in_access", {ifa.apb_sel, ifa.apb_enable}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("t5_async_ctl", {ifa.done0, ifa.done1, ifa.err, ifa.apb_sel, ifa.apb_enable, ifa.apb_w_en}, 0);
    check("t5_async_data", {ifa.apb_add, ifa.apb_wdata, ifa.rdata}, 0);
    tick();
    tick();
    check("t5_no_done", {ifa.done0, ifa.done1}, 2'b00);
    rst = 1'b0;
    ifa.apb_ready = 1;
    ifa.req0 = 1; ifa.addr0 = 8'h50;
    ifa.req1 = 1; ifa.wr1 = 0; ifa.addr1 = 8'h51;
    tick();
    check("t5_tie_to_req0", {ifa.apb_sel, ifa.apb_add}, {1'b1, 8'h50});
    tick();
    tick();
    check("t5_done0", {ifa.done0, ifa.done1}, 2'b10);
    ifa.req0 = 0; ifa.req1 = 0;
    tick();

    // ---- 6: timeout disabled, 300 wait states
    ifb.apb_ready = 0; ifb.apb_rdata = 8'h11;
    ifb.req0 = 1; ifb.wr0 = 0; ifb.addr0 = 8'h60;
    tick();
    tick();
    en = 0; saw = 0;
    for (int i = 1; i <= 301; i++) begin
      if (ifb.apb_enable) en++;
      if (ifb.done0) saw = 1;
      if (i == 301) begin
        ifb.apb_ready = 1; ifb.apb_rdata = 8'hA5;
      end
      tick();
    end
    check("t6_no_abort", saw, 1'b0);
    check("t6_access_cycles", en, 301);
    check("t6_done", {ifb.done0, ifb.err}, 2'b10);
    check("t6_rdata", ifb.rdata, 8'hA5);
    ifb.req0 = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
